video_timing_monitor: RTL and testbench

//  Receive-side counterpart of the core's H/V timing generator: samples HBLK/VBLK/HSYN/VSYN on the

---
 rtl/video_mon_pkg.sv | 14 +
 rtl/vmon_edge.sv | 27 ++
 rtl/video_timing_monitor.sv | 205 ++++++++++++++++++++
 tb/tb_video_timing_monitor.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/video_mon_pkg.sv
// Shared types and defaults for the video timing monitor.
package video_mon_pkg;

  localparam int CW_DEF    = 10;
  // Width of the matching-frame counter; LOCK_FRAMES ranges 1..15.
  localparam int LOCK_BITS = 4;

  typedef enum logic [1:0] {
    SEARCH,
    TRACK,
    LOCKED
  } vmon_state_t;

endpackage

// File: rtl/vmon_edge.sv
// CE-qualified edge detector: compares the current CE sample with the
// previous CE sample. The previous sample resets to the deasserted level.
module vmon_edge (
  input  logic mclk,
  input  logic reset,
  input  logic ce,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic prev;

  // Capture the input only on pixel enables; MCLK cycles between CEs are ignored.
  // NOTE: registers are assigned with <= so every always_ff reads pre-edge values.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      prev <= 1'b0;
    end else if (ce) begin
      prev <= d;
    end
  end

  assign rise = ce & d & ~prev;
  assign fall = ce & ~d & prev;

endmodule

// File: rtl/video_timing_monitor.sv
// Measures line/frame totals, active sizes and sync widths from sampled
// HBLK/VBLK/HSYN/VSYN, and qualifies a stable mode with a lock FSM.
module video_timing_monitor
  import video_mon_pkg::*;
#(
  parameter int CW          = CW_DEF,
  parameter int LOCK_FRAMES = 4,
  parameter bit SYNC_POL    = 1'b0
) (
  input  logic          mclk,
  input  logic          reset,
  input  logic          ce,
  input  logic          hblk,
  input  logic          vblk,
  input  logic          hsyn,
  input  logic          vsyn,
  output logic [CW-1:0] h_total,
  output logic [CW-1:0] h_active,
  output logic [CW-1:0] h_syncw,
  output logic [CW-1:0] v_total,
  output logic [CW-1:0] v_active,
  output logic [CW-1:0] v_syncw,
  output logic          frame_stb,
  output logic          locked,
  output logic          err
);

  localparam logic [CW-1:0]        CMAX   = '1;
  localparam logic [CW-1:0]        ONE    = CW'(1);
  localparam logic [LOCK_BITS-1:0] LOCK_N = LOCK_BITS'(LOCK_FRAMES);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CMAX) ? v : v + ONE;
  endfunction

  // Syncs are handled active-high from here on.
  logic hs_in, vs_in;
  assign hs_in = SYNC_POL ? hsyn : ~hsyn;
  assign vs_in = SYNC_POL ? vsyn : ~vsyn;

  logic hs_lead, hs_trail, vs_lead, vs_trail, hb_fall;
  logic hb_rise, vb_rise, vb_fall;
  logic unused_edges;
  assign unused_edges = hb_rise ^ vb_rise ^ vb_fall;

  vmon_edge u_hs (.mclk(mclk), .reset(reset), .ce(ce), .d(hs_in), .rise(hs_lead), .fall(hs_trail));
  vmon_edge u_vs (.mclk(mclk), .reset(reset), .ce(ce), .d(vs_in), .rise(vs_lead), .fall(vs_trail));
  vmon_edge u_hb (.mclk(mclk), .reset(reset), .ce(ce), .d(hblk),  .rise(hb_rise), .fall(hb_fall));
  vmon_edge u_vb (.mclk(mclk), .reset(reset), .ce(ce), .d(vblk),  .rise(vb_rise), .fall(vb_fall));

  logic [CW-1:0] hcnt, hact, hsw;
  logic [CW-1:0] h_tot, h_act, h_sw;
  logic [CW-1:0] vcnt, vact, vsw, v_sw;
  logic [CW-1:0] h_tot_n, h_act_n, h_sw_n, vcnt_n, vact_n;
  logic          ovf;
  logic          timeout;
  logic          match;
  vmon_state_t   state;
  logic [LOCK_BITS-1:0] mcnt;

  // Line/frame register values after this CE's edges, so a frame boundary
  // publishes a coincident line end in the same CE.
  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    h_tot_n = h_tot;
    h_act_n = h_act;
    h_sw_n  = h_sw;
    vcnt_n  = vcnt;
    vact_n  = vact;
    if (hs_lead) begin
      h_tot_n = sat_inc(hcnt);
      h_act_n = hact;
      vcnt_n  = sat_inc(vcnt);
    end
    if (hs_trail) begin
      h_sw_n = hsw;
    end
    if (hb_fall && !vblk) begin
      vact_n = sat_inc(vact);
    end
  end

  // hcnt is about to reach saturation: no HSYNC lead for 2^CW-1 CEs.
  assign timeout = ce && !hs_lead && (hcnt == CMAX - ONE);
  assign match   = (h_tot_n == h_total) && (vcnt_n == v_total) && !ovf;

  // Per-CE horizontal counters and the last-line registers.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      hcnt  <= '0;
      hact  <= '0;
      hsw   <= '0;
      h_tot <= '0;
      h_act <= '0;
      h_sw  <= '0;
      ovf   <= 1'b0;
    end else if (ce) begin
      if (hs_lead) begin
        hcnt <= '0;
        hact <= '0;
      end else begin
        hcnt <= sat_inc(hcnt);
        if (!hblk) hact <= sat_inc(hact);
      end
      if (hs_trail)   hsw <= '0;
      else if (hs_in) hsw <= sat_inc(hsw);
      if (timeout)      ovf <= 1'b1;
      else if (vs_lead) ovf <= 1'b0;
      h_tot <= h_tot_n;
      h_act <= h_act_n;
      h_sw  <= h_sw_n;
    end
  end

  // Per-line vertical counters; frame counters restart at each VSYNC lead.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      vcnt <= '0;
      vact <= '0;
      vsw  <= '0;
      v_sw <= '0;
    end else if (ce) begin
      if (vs_lead) begin
        vcnt <= '0;
        vact <= '0;
      end else begin
        vcnt <= vcnt_n;
        vact <= vact_n;
      end
      if (vs_trail) begin
        v_sw <= vsw;
        vsw  <= '0;
      end else if (hs_lead && vs_in) begin
        vsw <= sat_inc(vsw);
      end
    end
  end

  // Publish measurements at each frame boundary and run the lock FSM.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      h_total   <= '0;
      h_active  <= '0;
      h_syncw   <= '0;
      v_total   <= '0;
      v_active  <= '0;
      v_syncw   <= '0;
      frame_stb <= 1'b0;
      locked    <= 1'b0;
      err       <= 1'b0;
      state     <= SEARCH;
      mcnt      <= '0;
    end else begin
      frame_stb <= 1'b0;
      err       <= 1'b0;
      if (vs_lead) begin
        h_total   <= h_tot_n;
        h_active  <= h_act_n;
        h_syncw   <= h_sw_n;
        v_total   <= vcnt_n;
        v_active  <= vact_n;
        v_syncw   <= v_sw;
        frame_stb <= 1'b1;
      end
      if (timeout) begin
        state  <= SEARCH;
        locked <= 1'b0;
        mcnt   <= '0;
        if (state == LOCKED) err <= 1'b1;
      end else if (vs_lead) begin
        case (state)
          SEARCH: begin
            state <= TRACK;
            mcnt  <= '0;
          end
          TRACK: begin
            if (match) begin
              mcnt <= mcnt + 1'b1;
              if (mcnt + 1'b1 == LOCK_N) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              mcnt <= '0;
            end
          end
          LOCKED: begin
            if (!match) begin
              state  <= TRACK;
              locked <= 1'b0;
              mcnt   <= '0;
              err    <= 1'b1;
            end
          end
          default: begin
            state  <= SEARCH;
            locked <= 1'b0;
            mcnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_video_timing_monitor.sv
// Bench for video_timing_monitor: two instances (active-low and active-high
// sync polarity) see the same mode; each frame strobe is scored against a queue.
module tb_video_timing_monitor;

  localparam int CW = 10;
  // Compact synthetic mode: 32 CE lines, 20 active, 4 CE sync;
  // 20-line frames, 12 active, 3 sync lines.
  localparam int LINE   = 32;
  localparam int HA_LO  = 6;
  localparam int HA_HI  = 26;
  localparam int HS_W   = 4;
  localparam int VA_LO  = 4;
  localparam int VA_HI  = 16;
  localparam int VS_W   = 3;
  localparam int FRAME  = 20;

  typedef struct packed {
    logic [CW-1:0] ht, ha, hs, vt, va, vs;
    logic          locked, err;
  } meas_t;

  typedef struct {
    int    lines_next;
    meas_t exp;
  } vec_t;

  logic mclk = 1'b0;
  logic reset, ce, hblk, vblk, hs, vs;
  logic hsyn_lo, vsyn_lo;
  assign hsyn_lo = ~hs;
  assign vsyn_lo = ~vs;

  logic [CW-1:0] h_total0, h_active0, h_syncw0, v_total0, v_active0, v_syncw0;
  logic [CW-1:0] h_total1, h_active1, h_syncw1, v_total1, v_active1, v_syncw1;
  logic stb0, locked0, err0, stb1, locked1, err1;

  video_timing_monitor #(.CW(CW), .LOCK_FRAMES(4), .SYNC_POL(1'b0)) dut0 (
    .mclk(mclk), .reset(reset), .ce(ce), .hblk(hblk), .vblk(vblk),
    .hsyn(hsyn_lo), .vsyn(vsyn_lo),
    .h_total(h_total0), .h_active(h_active0), .h_syncw(h_syncw0),
    .v_total(v_total0), .v_active(v_active0), .v_syncw(v_syncw0),
    .frame_stb(stb0), .locked(locked0), .err(err0)
  );

  video_timing_monitor #(.CW(CW), .LOCK_FRAMES(4), .SYNC_POL(1'b1)) dut1 (
    .mclk(mclk), .reset(reset), .ce(ce), .hblk(hblk), .vblk(vblk),
    .hsyn(hs), .vsyn(vs),
    .h_total(h_total1), .h_active(h_active1), .h_syncw(h_syncw1),
    .v_total(v_total1), .v_active(v_active1), .v_syncw(v_syncw1),
    .frame_stb(stb1), .locked(locked1), .err(err1)
  );

  meas_t obs0, obs1;
  assign obs0 = {h_total0, h_active0, h_syncw0, v_total0, v_active0, v_syncw0, locked0, err0};
  assign obs1 = {h_total1, h_active1, h_syncw1, v_total1, v_active1, v_syncw1, locked1, err1};

  always #5 mclk = ~mclk;

  int    checks = 0;
  int    errors = 0;
  int    gap    = 1;
  int    ce_seen = 0;
  int    err_cnt0 = 0, err_cnt1 = 0;
  int    err_ce0 = 0, err_ce1 = 0;
  meas_t sb[$];
  vec_t  tbl[13];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  task automatic cmp(input string who, input meas_t got, input meas_t exp);
    check({who, " h_total"},  32'(got.ht), 32'(exp.ht));
    check({who, " h_active"}, 32'(got.ha), 32'(exp.ha));
    check({who, " h_syncw"},  32'(got.hs), 32'(exp.hs));
    check({who, " v_total"},  32'(got.vt), 32'(exp.vt));
    check({who, " v_active"}, 32'(got.va), 32'(exp.va));
    check({who, " v_syncw"},  32'(got.vs), 32'(exp.vs));
    check({who, " locked"},   32'(got.locked), 32'(exp.locked));
    check({who, " err"},      32'(got.err), 32'(exp.err));
  endtask

  function automatic meas_t mk(input int ht, ha, hsw, vt, va, vsw, input bit l, e);
    meas_t m;
    m.ht = CW'(ht); m.ha = CW'(ha); m.hs = CW'(hsw);
    m.vt = CW'(vt); m.va = CW'(va); m.vs = CW'(vsw);
    m.locked = l; m.err = e;
    return m;
  endfunction

  // Count CEs the DUT actually samples.
  always @(posedge mclk) begin
    if (ce && !reset) ce_seen <= ce_seen + 1;
  end

  // Score every frame strobe against the oldest expected record.
  always @(negedge mclk) begin
    meas_t e;
    if (err0) begin err_cnt0++; err_ce0 = ce_seen; end
    if (err1) begin err_cnt1++; err_ce1 = ce_seen; end
    if (stb0 || stb1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected frame_stb: got d0=%0d d1=%0d, required none", stb0, stb1);
      end else begin
        e = sb.pop_front();
        check("d0 frame_stb", 32'(stb0), 32'd1);
        check("d1 frame_stb", 32'(stb1), 32'd1);
        cmp("d0", obs0, e);
        cmp("d1", obs1, e);
      end
    end
  end

  task automatic tick(input logic hb, input logic vb, input logic h, input logic v);
    @(negedge mclk);
    hblk = hb; vblk = vb; hs = h; vs = v; ce = 1'b1;
    for (int i = 1; i < gap; i++) begin
      @(negedge mclk);
      ce = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge mclk);
      ce = 1'b0;
    end
  endtask

  task automatic gen_lines(input int y0, input int y1);
    for (int y = y0; y < y1; y++) begin
      for (int x = 0; x < LINE; x++) begin
        tick(!(x >= HA_LO && x < HA_HI), !(y >= VA_LO && y < VA_HI), x < HS_W, y < VS_W);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " d0 outputs"}, 32'(|obs0 | stb0), 32'd0);
    check({tag, " d1 outputs"}, 32'(|obs1 | stb1), 32'd0);
  endtask

  task automatic run_table(input int n);
    for (int i = 0; i < n; i++) begin
      sb.push_back(tbl[i].exp);
      gen_lines(0, tbl[i].lines_next);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1);
  end

  initial begin
    int base, e0, e1;
    meas_t good;
    good = mk(LINE, HA_HI - HA_LO, HS_W, FRAME, VA_HI - VA_LO, VS_W, 1'b0, 1'b0);

    // Boundary vectors: expected measurement at each VSYNC lead, then the
    // length of the frame that follows it.
    tbl[0]  = '{FRAME,     mk(1, 0, 0, 1, 0, 0, 1'b0, 1'b0)};
    for (int i = 1; i <= 4; i++) tbl[i] = '{FRAME, good};
    tbl[5]  = '{FRAME,     mk(LINE, 20, HS_W, FRAME, 12, VS_W, 1'b1, 1'b0)};
    tbl[6]  = '{FRAME + 1, mk(LINE, 20, HS_W, FRAME, 12, VS_W, 1'b1, 1'b0)};
    tbl[7]  = '{FRAME,     mk(LINE, 20, HS_W, FRAME + 1, 12, VS_W, 1'b0, 1'b1)};
    for (int i = 8; i <= 11; i++) tbl[i] = '{FRAME, good};
    tbl[12] = '{FRAME,     mk(LINE, 20, HS_W, FRAME, 12, VS_W, 1'b1, 1'b0)};

    reset = 1'b1; ce = 1'b0; hblk = 1'b0; vblk = 1'b0; hs = 1'b0; vs = 1'b0;
    idle(3);
    check_all_zero("reset state");
    reset = 1'b0;
    idle(2);

    // Acquire, lock, disturb with a long frame, relock.
    run_table(13);
    idle(4);
    check("lock phase d0 err pulses", 32'(err_cnt0), 32'd1);
    check("lock phase d1 err pulses", 32'(err_cnt1), 32'd1);

    // HSYNC stops after a frame boundary: timeout on the 1023rd CE.
    e0 = err_cnt0; e1 = err_cnt1;
    sb.push_back(mk(LINE, 20, HS_W, FRAME, 12, VS_W, 1'b1, 1'b0));
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    idle(1);
    base = ce_seen;
    repeat (1100) tick(1'b1, 1'b1, 1'b0, 1'b0);
    idle(3);
    check("timeout d0 err pulses", 32'(err_cnt0 - e0), 32'd1);
    check("timeout d1 err pulses", 32'(err_cnt1 - e1), 32'd1);
    check("timeout d0 err ce", 32'(err_ce0 - base), 32'd1023);
    check("timeout d1 err ce", 32'(err_ce1 - base), 32'd1023);
    check("timeout d0 locked", 32'(locked0), 32'd0);
    check("timeout d1 locked", 32'(locked1), 32'd0);
    check("timeout d0 h_total hold", 32'(h_total0), 32'(LINE));
    check("timeout d0 v_total hold", 32'(v_total0), 32'(FRAME));

    // Mid-frame reset clears everything asynchronously.
    gen_lines(5, 8);
    @(negedge mclk);
    ce = 1'b0;
    reset = 1'b1;
    #1;
    check_all_zero("async reset");
    @(negedge mclk);
    check_all_zero("reset next cycle");
    hs = 1'b0; vs = 1'b0;
    @(negedge mclk);
    reset = 1'b0;
    idle(2);

    // Same mode with CE one MCLK in eight.
    gap = 8;
    e0 = err_cnt0;
    run_table(6);
    idle(20);
    check("gated d0 locked", 32'(locked0), 32'd1);
    check("gated d1 locked", 32'(locked1), 32'd1);
    check("gated d0 err pulses", 32'(err_cnt0 - e0), 32'd0);
    check("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
